// File: rtl/cmp_branch_unit.sv
// cmp_branch_unit: two-stage compare-and-resolve pipe wrapped around comp16b.
// Stage 1 registers the operand pair, condition and tag. The registered operands
// feed comp16b. Stage 2 holds the resolved taken bit, the tag and the sticky
// gt/eq/lt flags of the last completed compare.
// Build option: define SIGNED_CMP_EN for a two's-complement compare. The comparison
// is unsigned when the macro is not defined.

// comp16b: 16-bit unsigned magnitude comparator.
module comp16b (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_gt,
  output logic        o_eq
);
  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);
endmodule

module cmp_branch_unit #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_gt,
  output logic             flag_eq,
  output logic             flag_lt
);

  // comp16b is a fixed 16-bit block, so no other operand width can work.
  if (WIDTH != 16) begin : g_width_check
    $error("cmp_branch_unit: WIDTH must be 16");
  end

  localparam logic [2:0] C_EQ     = 3'b000;
  localparam logic [2:0] C_NE     = 3'b001;
  localparam logic [2:0] C_GT     = 3'b010;
  localparam logic [2:0] C_GE     = 3'b011;
  localparam logic [2:0] C_LT     = 3'b100;
  localparam logic [2:0] C_LE     = 3'b101;
  localparam logic [2:0] C_ALWAYS = 3'b110;

  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_cond;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_valid;

  logic             r_out_valid;
  logic             r_out_taken;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_flag_gt;
  logic             r_flag_eq;
  logic             r_flag_lt;

  logic             w_s2_load;
  logic             w_accept;
  logic [15:0]      w_cmp_a;
  logic [15:0]      w_cmp_b;
  logic             w_gt;
  logic             w_eq;
  logic             w_cond_true;

  // Stage 2 takes the stage-1 item when stage 2 is empty or is being drained this cycle.
  // in_ready does not depend on in_valid, so a full pipe can still accept without a bubble.
  assign w_s2_load = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s2_load;
  assign w_accept  = in_valid & in_ready;

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_cmp_a = {~r_s1_a[WIDTH-1], r_s1_a[WIDTH-2:0]};
  assign w_cmp_b = {~r_s1_b[WIDTH-1], r_s1_b[WIDTH-2:0]};
`else
  assign w_cmp_a = r_s1_a;
  assign w_cmp_b = r_s1_b;
`endif

  comp16b u_comp16b (
    .i_a  (w_cmp_a),
    .i_b  (w_cmp_b),
    .o_gt (w_gt),
    .o_eq (w_eq)
  );

  // Resolve the registered condition code against the comparator outputs.
  always_comb begin
    w_cond_true = 1'b0;
    unique case (r_s1_cond)
      C_EQ:     w_cond_true = w_eq;
      C_NE:     w_cond_true = ~w_eq;
      C_GT:     w_cond_true = w_gt;
      C_GE:     w_cond_true = w_gt | w_eq;
      C_LT:     w_cond_true = ~w_gt & ~w_eq;
      C_LE:     w_cond_true = ~w_gt;
      C_ALWAYS: w_cond_true = 1'b1;
      default:  w_cond_true = 1'b0;
    endcase
  end

  // Stage-1 payload. It is only meaningful while r_s1_valid is set, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a    <= in_a;
      r_s1_b    <= in_b;
      r_s1_cond <= in_cond;
      r_s1_tag  <= in_tag;
    end
  end

  // Stage-1 occupancy. A new accept takes priority over draining to stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage-2 result and sticky flags. Both change only when a compare completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_taken <= 1'b0;
      r_out_tag   <= '0;
      r_flag_gt   <= 1'b0;
      r_flag_eq   <= 1'b0;
      r_flag_lt   <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_out_taken <= w_cond_true;
      r_out_tag   <= r_s1_tag;
      r_flag_gt   <= w_gt;
      r_flag_eq   <= w_eq;
      r_flag_lt   <= ~w_gt & ~w_eq;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_taken = r_out_taken;
  assign out_tag   = r_out_tag;
  assign flag_gt   = r_flag_gt;
  assign flag_eq   = r_flag_eq;
  assign flag_lt   = r_flag_lt;

endmodule
